sysid_checker: RTL and testbench
================================

// Module: sysid_checker
// PURPOSE
//  Avalon-MM read master that consumes the system-ID slave's control port.
//  Reads ID word (address 0) then timestamp word (address 1); compares both
//  against build-time expected values; reports pass/fail and timeout.
//  Sits between sysid slave and the board status/LED logic.
//  Gates host DMA enable until the hardware build is confirmed.
// PARAMETERS
//  EXPECTED_ID    32'h556174D8  expected word at address 0
//  EXPECTED_TS    32'h4DEE4B26  expected word at address 1
//  TIMEOUT_CYCLES 256           max waitrequest cycles per read (>=2)
//  AUTO_START     1             1: start a check on the first cycle after reset
// PORTS
//  clk              in   1   system clock
//  reset_n          in   1   synchronous active-low reset
//  start            in   1   pulse: begin check (ignored while busy)
//  avm_address      out  1   0=ID word, 1=timestamp word
//  avm_read         out  1   read strobe
//  avm_readdata     in   32  slave read data
//  avm_waitrequest  in   1   slave stall
//  busy             out  1   check in progress
//  done             out  1   1-cycle pulse when check ends
//  id_ok            out  1   sticky: ID matched on last check
//  ts_ok            out  1   sticky: timestamp matched on last check
//  timeout          out  1   sticky: a read exceeded TIMEOUT_CYCLES
//  id_value         out  32  ID word captured on last check
//  ts_value         out  32  timestamp captured on last check
// BEHAVIOUR
//  Reset (reset_n=0 at clk edge): state IDLE; all outputs 0; wait counter 0.
//   Reset mid-read drops avm_read on the next edge; no result is reported.
//  FSM: IDLE -> RD_ID -> RD_TS -> CHECK -> IDLE.
//  IDLE: start=1 (or first post-reset cycle if AUTO_START) -> RD_ID next edge;
//   entering RD_ID clears id_ok/ts_ok/timeout/id_value/ts_value.
//  RD_ID: avm_read=1, avm_address=0, held stable while avm_waitrequest=1.
//   On read & !waitrequest: capture id_value, -> RD_TS.
//  RD_TS: same with address 1; capture ts_value, -> CHECK.
//  Read latency: data taken in the same cycle waitrequest is low; min 1 cycle/read.
//  Wait counter: increments each cycle read is stalled; reset on state entry.
//   Counter reaching TIMEOUT_CYCLES-1 while still stalled: set timeout,
//   deassert read, -> CHECK (unread word stays 0, its ok flag stays 0).
//  CHECK (1 cycle): id_ok = (id_value==EXPECTED_ID) & !timeout-on-ID;
//   ts_ok likewise; done=1 this cycle only; -> IDLE.
//  busy=1 in RD_ID, RD_TS, CHECK; avm_read=0 in IDLE and CHECK.
//  start while busy: ignored, not queued. start in the CHECK cycle: ignored.
//  start on the same cycle done pulses: ignored; next start accepted from IDLE.
//  Compare is full 32-bit equality; no masking. Counter width $clog2(TIMEOUT_CYCLES).
// STRUCTURE
//  Shared package sysid_pkg: state enum (IDLE,RD_ID,RD_TS,CHECK),
//   SYSID_ADDR_ID=1'b0, SYSID_ADDR_TS=1'b1, default expected-value constants.
//  One sub-module: sysid_wait_timer (load/enable counter, expired flag).
//  Single clocked always block for FSM + captures; combinational outputs decode.
// TESTING
//  1 Slave returns 556174D8/4DEE4B26, waitrequest=0, AUTO_START=1 -> done at
//    cycle 4 after reset release, id_ok=1, ts_ok=1, timeout=0.
//  2 Timestamp returns 4DEE4B27 -> id_ok=1, ts_ok=0, ts_value=4DEE4B27.
//  3 waitrequest high 10 cycles on each read -> address/read stable throughout,
//    done 22 cycles after start, both ok=1.
//  4 waitrequest stuck high, TIMEOUT_CYCLES=8 -> read drops after 8 cycles,
//    timeout=1, id_ok=0, ts_ok=0, done pulses once.
//  5 reset_n low during RD_TS -> next cycle avm_read=0, all outputs 0, no done.
//  6 start pulsed while busy and on done cycle -> exactly one check per
//    accepted start; second check re-clears flags before reading.

Source files
------------

// File: rtl/sysid_pkg.sv
// sysid_pkg: shared types and constants for the system-ID checker.
//   state_e           checker FSM states
//   SYSID_ADDR_*      word addresses on the sysid slave control port
//   SYSID_DEFAULT_*   build-time expected ID and timestamp words
package sysid_pkg;

    typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, CHECK} state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_DEFAULT_ID = 32'h556174D8;
    localparam logic [31:0] SYSID_DEFAULT_TS = 32'h4DEE4B26;

endpackage

// File: rtl/sysid_wait_timer.sv
// sysid_wait_timer: counts consecutive stalled read cycles and flags expiry.
//   clk_i      system clock
//   reset_n_i  synchronous active-low reset
//   clr_i      clear the count (takes priority over en_i)
//   en_i       count this cycle (read stalled)
//   expired_o  stalled on the LIMIT-th consecutive cycle
module sysid_wait_timer
    import sysid_pkg::*;
#(
    parameter int unsigned LIMIT = 256
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned W = $clog2(LIMIT);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + W'(1) : cnt_q;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end

    // Gated by en_i so expiry only fires while the read is still stalled.
    assign expired_o = en_i && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM read master that verifies the sysid slave's
// ID and timestamp words against build-time values.
//   clk_i              system clock
//   reset_n_i          synchronous active-low reset
//   start_i            pulse: begin a check (ignored unless idle)
//   avm_address_o      0 = ID word, 1 = timestamp word
//   avm_read_o         read strobe
//   avm_readdata_i     slave read data
//   avm_waitrequest_i  slave stall
//   busy_o             check in progress
//   done_o             one-cycle pulse when a check ends
//   id_ok_o, ts_ok_o   sticky match results of the last check
//   timeout_o          sticky: a read stalled too long
//   id_value_o, ts_value_o  words captured on the last check
module sysid_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        start_i,
    output logic        avm_address_o,
    output logic        avm_read_o,
    input  logic [31:0] avm_readdata_i,
    input  logic        avm_waitrequest_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        id_ok_o,
    output logic        ts_ok_o,
    output logic        timeout_o,
    output logic [31:0] id_value_o,
    output logic [31:0] ts_value_o
);

    state_e      state_q, state_d;
    logic        auto_q;
    logic        id_ok_q, ts_ok_q, timeout_q;
    logic [31:0] id_value_q, ts_value_q;
    logic        stall, accept, expired;

    assign stall  = avm_read_o && avm_waitrequest_i;
    assign accept = avm_read_o && !avm_waitrequest_i;

    // Counter restarts on every state change, so each read gets its own budget.
    sysid_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clr_i     (state_d != state_q),
        .en_i      (stall),
        .expired_o (expired)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            auto_q     <= AUTO_START;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            timeout_q  <= 1'b0;
            id_value_q <= '0;
            ts_value_q <= '0;
        end else begin
            state_q <= state_d;
            auto_q  <= 1'b0;
            if (state_q == IDLE && state_d == RD_ID) begin
                id_ok_q    <= 1'b0;
                ts_ok_q    <= 1'b0;
                timeout_q  <= 1'b0;
                id_value_q <= '0;
                ts_value_q <= '0;
            end
            if (state_q == RD_ID && accept) id_value_q <= avm_readdata_i;
            if (state_q == RD_TS && accept) begin
                ts_value_q <= avm_readdata_i;
                ts_ok_q    <= avm_readdata_i == EXPECTED_TS;
            end
            // RD_TS is only reachable after a good ID read, so the ID verdict
            // is settled on leaving RD_TS; an ID timeout leaves id_ok cleared.
            if (state_q == RD_TS && state_d == CHECK) id_ok_q <= id_value_q == EXPECTED_ID;
            if (expired) timeout_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (start_i || auto_q) ? RD_ID : IDLE;
            RD_ID:   state_d = !avm_waitrequest_i ? RD_TS : expired ? CHECK : RD_ID;
            RD_TS:   state_d = (!avm_waitrequest_i || expired) ? CHECK : RD_TS;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o        = state_q != IDLE;
        avm_read_o    = state_q == RD_ID || state_q == RD_TS;
        avm_address_o = state_q == RD_TS ? SYSID_ADDR_TS : SYSID_ADDR_ID;
        done_o        = state_q == CHECK;
    end

    assign id_ok_o    = id_ok_q;
    assign ts_ok_o    = ts_ok_q;
    assign timeout_o  = timeout_q;
    assign id_value_o = id_value_q;
    assign ts_value_o = ts_value_q;

endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: randomized scoreboard bench for sysid_checker.
module tb_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'h556174D8;
    localparam logic [31:0] EXP_TS = 32'h4DEE4B26;
    localparam int          T      = 12;

    typedef struct {
        logic [31:0] idv;
        logic [31:0] tsv;
        bit          idok;
        bit          tsok;
        bit          to;
        int          lat;
        int          cyc;
    } exp_t;

    logic        clk = 0, reset_n = 0, start = 0, wr = 0;
    logic [31:0] rdata = 0;
    logic        avm_address, avm_read, busy, done, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;

    logic [31:0] cfg_id = EXP_ID, cfg_ts = EXP_TS;
    int          cfg_sid = 0, cfg_sts = 0, sc = 0;
    int          cyc = 0, checks = 0, errors = 0;
    exp_t        sb[$];
    logic        prev_rd = 0, prev_addr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sysid_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
        .TIMEOUT_CYCLES(T), .AUTO_START(1'b1)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start),
        .avm_address_o(avm_address), .avm_read_o(avm_read),
        .avm_readdata_i(rdata), .avm_waitrequest_i(wr),
        .busy_o(busy), .done_o(done), .id_ok_o(id_ok), .ts_ok_o(ts_ok),
        .timeout_o(timeout), .id_value_o(id_value), .ts_value_o(ts_value)
    );

    task automatic chk(string n, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", n, got, want);
        end
    endtask

    // Reference: each read stalls s cycles; s >= T means the read times out.
    function automatic exp_t model(logic [31:0] idd, logic [31:0] tsd, int sid, int sts);
        exp_t m;
        bit ito = sid >= T;
        bit tto = !ito && sts >= T;
        m.idv  = ito ? 32'd0 : idd;
        m.tsv  = (ito || tto) ? 32'd0 : tsd;
        m.idok = !ito && idd == EXP_ID;
        m.tsok = !ito && !tto && tsd == EXP_TS;
        m.to   = ito || tto;
        m.lat  = (ito ? T : sid + 1) + (ito ? 0 : (tto ? T : sts + 1));
        m.cyc  = 0;
        return m;
    endfunction

    // Slave: stalls each read for its configured count, garbage data while stalled.
    initial forever begin
        @(negedge clk);
        if (avm_read) begin
            wr    = sc < (avm_address ? cfg_sts : cfg_sid);
            rdata = wr ? $urandom : (avm_address ? cfg_ts : cfg_id);
            sc    = wr ? sc + 1 : 0;
        end else begin
            wr    = 1'($urandom_range(0, 1));
            rdata = $urandom;
            sc    = 0;
        end
    end

    // Monitor: request stability during stalls, and scoreboard pop on done.
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (prev_rd && wr && avm_read) chk("addr_stable", 32'(avm_address), 32'(prev_addr));
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got done=1 want no done at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("busy_on_done", 32'(busy), 32'd1);
                chk("id_value", id_value, e.idv);
                chk("ts_value", ts_value, e.tsv);
                chk("id_ok", 32'(id_ok), 32'(e.idok));
                chk("ts_ok", 32'(ts_ok), 32'(e.tsok));
                chk("timeout", 32'(timeout), 32'(e.to));
            end
        end
        prev_rd   = avm_read;
        prev_addr = avm_address;
    end

    // Caller has raised start (or released reset) at a negedge; the next edge starts the check.
    task automatic issue(logic [31:0] idd, logic [31:0] tsd, int sid, int sts);
        exp_t e;
        cfg_id  = idd;
        cfg_ts  = tsd;
        cfg_sid = sid;
        cfg_sts = sts;
        @(posedge clk);
        #1;
        start = 0;
        e     = model(idd, tsd, sid, sts);
        e.cyc = cyc + e.lat;
        sb.push_back(e);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_read", 32'(avm_read), 32'd1);
        chk("clr_timeout", 32'(timeout), 32'd0);
        chk("clr_id_ok", 32'(id_ok), 32'd0);
        chk("clr_id_value", id_value, 32'd0);
    endtask

    task automatic wait_done(bit extra);
        bit got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            start = 0;
            if (done) begin
                got   = 1;
                start = extra && $urandom_range(0, 1) == 1;
            end else if (extra && busy && $urandom_range(0, 2) == 0) start = 1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_wait got no done want done within 200 cycles");
        end
        @(negedge clk);
        start = 0;
    endtask

    task automatic run(logic [31:0] idd, logic [31:0] tsd, int sid, int sts, bit extra);
        @(negedge clk);
        start = 1;
        issue(idd, tsd, sid, sts);
        wait_done(extra);
    endtask

    task automatic check_zero(string n);
        chk({n, "_read"}, 32'(avm_read), 32'd0);
        chk({n, "_addr"}, 32'(avm_address), 32'd0);
        chk({n, "_busy"}, 32'(busy), 32'd0);
        chk({n, "_done"}, 32'(done), 32'd0);
        chk({n, "_id_ok"}, 32'(id_ok), 32'd0);
        chk({n, "_ts_ok"}, 32'(ts_ok), 32'd0);
        chk({n, "_timeout"}, 32'(timeout), 32'd0);
        chk({n, "_id_value"}, id_value, 32'd0);
        chk({n, "_ts_value"}, ts_value, 32'd0);
    endtask

    // Called at a negedge; the released DUT auto-starts a check on its first edge.
    task automatic do_reset(string n, logic [31:0] idd, logic [31:0] tsd, int sid, int sts);
        reset_n = 0;
        start   = 0;
        @(posedge clk);
        #1;
        sb.delete();
        check_zero(n);
        repeat (2) @(negedge clk);
        reset_n = 1;
        issue(idd, tsd, sid, sts);
        wait_done(0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got no finish want finish before 1ms");
        $fatal(1);
    end

    initial begin
        logic [31:0] idd, tsd;
        int          r, sid, sts;
        bit          reached;
        do_reset("rst", EXP_ID, EXP_TS, 0, 0);
        run(EXP_ID, 32'h4DEE4B27, 0, 0, 0);
        run(EXP_ID, EXP_TS, 10, 10, 0);
        run(EXP_ID, EXP_TS, 1000, 0, 0);
        run(EXP_ID, EXP_TS, 0, 0, 0);
        run(EXP_ID, EXP_TS, 3, 1000, 0);
        run(EXP_ID, EXP_TS, T - 1, T - 1, 0);
        run(EXP_ID ^ 32'h8000_0000, EXP_TS, T - 1, T, 0);
        run(EXP_ID, EXP_TS, 2, 2, 1);
        run(32'h0, 32'h0, 4, 1, 1);
        @(negedge clk);
        start = 1;
        issue(EXP_ID, EXP_TS, 2, 6);
        reached = 0;
        for (int i = 0; i < 50 && !reached; i++) begin
            @(negedge clk);
            reached = avm_read && avm_address;
        end
        chk("reach_rd_ts", 32'(reached), 32'd1);
        do_reset("mid_rst", EXP_ID, EXP_TS, 0, 0);
        for (int n = 0; n < 40; n++) begin
            r   = $urandom_range(0, 3);
            idd = r == 0 ? $urandom : r == 1 ? EXP_ID ^ (32'd1 << $urandom_range(0, 31)) : EXP_ID;
            r   = $urandom_range(0, 3);
            tsd = r == 0 ? $urandom : r == 1 ? EXP_TS ^ (32'd1 << $urandom_range(0, 31)) : EXP_TS;
            sid = $urandom_range(0, 9) == 0 ? $urandom_range(T, T + 2) : $urandom_range(0, T - 1);
            sts = $urandom_range(0, 9) == 0 ? $urandom_range(T, T + 2) : $urandom_range(0, T - 1);
            run(idd, tsd, sid, sts, 1'($urandom_range(0, 1)));
        end
        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
